// File: rtl/conway_pkg.sv
// Shared constants and FSM state encoding for the Conway row-window feeder.
package conway_pkg;

    // Columns per row word: accelerator output slice plus one halo column each side.
    localparam int ROW_W = 22;
    localparam int OUT_W = ROW_W - 2;

    // Window builder FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/conway_row_window.sv
// Conway row-window feeder: accepts grid rows in frame order and presents a
// 3-row sliding window (top/middle/bottom) per grid row, with zero rows above
// row 0 and below the last row.
// Optional build macro CONWAY_STALL_CNT_EN adds a saturating stall_cnt output
// counting cycles where a window is offered but not taken.
//
// Handshake rule for both interfaces: a transfer happens in a cycle where
// valid && ready are both high at the rising edge; valid, once raised, holds
// its payload stable until that transfer; ready never looks at valid.
module conway_row_window
    import conway_pkg::*;
#(
    parameter int NUM_ROWS = 480
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ROW_W-1:0]            row_in,
    input  logic                        row_valid,
    output logic                        row_ready,
    output logic [ROW_W-1:0]            top_row,
    output logic [ROW_W-1:0]            middle_row,
    output logic [ROW_W-1:0]            bottom_row,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [$clog2(NUM_ROWS)-1:0] win_row,
    output logic                        frame_done,
    output state_t                      dbg_state
`ifdef CONWAY_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int WR_W  = $clog2(NUM_ROWS);
    localparam int CNT_W = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROWS);

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] rx_cnt_q,     rx_cnt_d;
    logic [ROW_W-1:0] top_q,        top_d;
    logic [ROW_W-1:0] mid_q,        mid_d;
    logic [ROW_W-1:0] bot_q,        bot_d;
    logic             win_valid_q,  win_valid_d;
    logic [WR_W-1:0]  win_row_q,    win_row_d;
    logic             frame_done_q, frame_done_d;

    logic row_acc;
    logic win_acc;

    // Input readiness depends only on state, row count and the output side.
    always_comb begin
        row_ready = 1'b0;
        case (state_q)
            S_IDLE:  row_ready = 1'b1;
            S_FILL:  row_ready = 1'b1;
            S_RUN:   row_ready = (rx_cnt_q < LAST_CNT) && (!win_valid_q || win_ready);
            default: row_ready = 1'b0;
        endcase
    end

    assign row_acc = row_valid && row_ready;
    assign win_acc = win_valid_q && win_ready;

    // Window shift register and FSM next-state logic.
    always_comb begin
        state_d      = state_q;
        rx_cnt_d     = rx_cnt_q;
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (row_acc) begin
                    top_d    = '0;
                    mid_d    = row_in;
                    rx_cnt_d = CNT_W'(1);
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (row_acc) begin
                    bot_d       = row_in;
                    rx_cnt_d    = CNT_W'(2);
                    win_valid_d = 1'b1;
                    win_row_d   = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (row_acc) begin
                    // Either the shown window is taken this cycle or it was
                    // already taken earlier; both cases advance the index.
                    top_d       = mid_q;
                    mid_d       = bot_q;
                    bot_d       = row_in;
                    rx_cnt_d    = rx_cnt_q + 1'b1;
                    win_valid_d = 1'b1;
                    win_row_d   = win_row_q + 1'b1;
                end else if (win_acc && (rx_cnt_q < LAST_CNT)) begin
                    win_valid_d = 1'b0;
                end else if (win_acc) begin
                    // All rows in: the final window has a dead row below.
                    top_d     = mid_q;
                    mid_d     = bot_q;
                    bot_d     = '0;
                    win_row_d = win_row_q + 1'b1;
                    state_d   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (win_acc) begin
                    win_valid_d  = 1'b0;
                    frame_done_d = 1'b1;
                    rx_cnt_d     = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rx_cnt_q     <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_cnt_q     <= rx_cnt_d;
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign top_row    = top_q;
    assign middle_row = mid_q;
    assign bottom_row = bot_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

`ifdef CONWAY_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where the consumer holds off a valid window.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && row_acc) begin
            stall_cnt_d = '0;
        end else if (win_valid_q && !win_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conway_row_window.sv
// Directed bench for conway_row_window: a per-cycle vector table on a
// 4-row-frame instance plus hand sequences for reset mid-frame and the
// 2-row minimum frame. A window monitor cross-checks accepted windows.
module tb_conway_row_window;
  import conway_pkg::*;

  localparam int W = ROW_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic [W-1:0] row_in = '0;
  logic         row_valid = 1'b0;
  logic         win_ready = 1'b0;

  // 4-row-frame instance
  logic         rr4, wv4, fd4;
  logic [W-1:0] top4, mid4, bot4;
  logic [1:0]   wrow4;
  state_t       st4;
  // 2-row-frame instance
  logic         rr2, wv2, fd2;
  logic [W-1:0] top2, mid2, bot2;
  logic [0:0]   wrow2;
  state_t       st2;
`ifdef CONWAY_STALL_CNT_EN
  logic [31:0]  stall4, stall2;
`endif

  conway_row_window #(.NUM_ROWS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .row_in(row_in), .row_valid(row_valid),
    .row_ready(rr4), .top_row(top4), .middle_row(mid4), .bottom_row(bot4),
    .win_valid(wv4), .win_ready(win_ready), .win_row(wrow4),
    .frame_done(fd4), .dbg_state(st4)
`ifdef CONWAY_STALL_CNT_EN
    , .stall_cnt(stall4)
`endif
  );

  conway_row_window #(.NUM_ROWS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .row_in(row_in), .row_valid(row_valid),
    .row_ready(rr2), .top_row(top2), .middle_row(mid2), .bottom_row(bot2),
    .win_valid(wv2), .win_ready(win_ready), .win_row(wrow2),
    .frame_done(fd2), .dbg_state(st2)
`ifdef CONWAY_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [3*W-1:0] exp_q[$];
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every window taken by the consumer must match the next expected window.
  always @(negedge clk) begin
    if (mon_en && wv4 && win_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_extra_window actual=%0h required=none", {top4, mid4, bot4});
      end else begin
        logic [3*W-1:0] e;
        e = exp_q.pop_front();
        chk("mon_window", 32'({top4, mid4, bot4} != e), 32'd0);
        if ({top4, mid4, bot4} != e)
          $display("  window was %0h/%0h/%0h", top4, mid4, bot4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rv, input logic [W-1:0] row, input logic wr);
    @(posedge clk);
    #1;
    row_valid = rv;
    row_in    = row;
    win_ready = wr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    row_valid = 1'b0;
    row_in    = '0;
    win_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rv;
    logic [W-1:0] row;
    logic         wr;
    logic         wv;
    logic [W-1:0] top;
    logic [W-1:0] mid;
    logic [W-1:0] bot;
    logic [1:0]   wrow;
    logic         rr;
    logic         fd;
    logic         st_en;
    logic [31:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rv, input logic [W-1:0] row, input logic wr,
                              input logic wv, input logic [W-1:0] top, input logic [W-1:0] mid,
                              input logic [W-1:0] bot, input logic [1:0] wrow,
                              input logic rr, input logic fd);
    vec_t v;
    v.rv = rv; v.row = row; v.wr = wr; v.wv = wv;
    v.top = top; v.mid = mid; v.bot = bot; v.wrow = wrow;
    v.rr = rr; v.fd = fd; v.st_en = 1'b0; v.st = '0;
    vecs.push_back(v);
  endfunction

  initial begin
    // frame 1: basic frame, rows 1,2,4,8, consumer always ready
    add(1, 'h1,  1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h2,  1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h4,  1, 1, 0, 1, 2, 0, 1, 0);
    add(1, 'h8,  1, 1, 1, 2, 4, 1, 1, 0);
    add(0, 'h0,  1, 1, 2, 4, 8, 2, 0, 0);
    add(0, 'h0,  1, 1, 4, 8, 0, 3, 0, 0);
    // frame_done cycle; frame 2 row 0 accepted right here
    add(1, 'h10, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h20, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h40, 1, 1, 0, 'h10, 'h20, 0, 1, 0);
    // 5-cycle output backpressure on window r1
    for (int i = 0; i < 5; i++)
      add(1, 'h80, 0, 1, 'h10, 'h20, 'h40, 1, 0, 0);
    add(1, 'h80, 1, 1, 'h10, 'h20, 'h40, 1, 1, 0);
    vecs[vecs.size()-1].st_en = 1'b1;
    vecs[vecs.size()-1].st    = 32'd5;
    add(0, 'h0,  1, 1, 'h20, 'h40, 'h80, 2, 0, 0);
    add(0, 'h0,  0, 1, 'h40, 'h80, 0, 3, 0, 0);
    add(0, 'h0,  1, 1, 'h40, 'h80, 0, 3, 0, 0);
    add(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 'h0,  0, 0, 0, 0, 0, 0, 1, 0);
    // frame 3: input starvation after row 2
    add(1, 'h1,  1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h2,  1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h4,  1, 1, 0, 1, 2, 0, 1, 0);
    add(0, 'h0,  1, 1, 1, 2, 4, 1, 1, 0);
    add(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 'h8,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 'h0,  1, 1, 2, 4, 8, 2, 0, 0);
    add(0, 'h0,  1, 1, 4, 8, 0, 3, 0, 0);
    add(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 1);

    // windows the consumer takes during the table, in order
    exp_q.push_back({22'h0,  22'h1,  22'h2});
    exp_q.push_back({22'h1,  22'h2,  22'h4});
    exp_q.push_back({22'h2,  22'h4,  22'h8});
    exp_q.push_back({22'h4,  22'h8,  22'h0});
    exp_q.push_back({22'h0,  22'h10, 22'h20});
    exp_q.push_back({22'h10, 22'h20, 22'h40});
    exp_q.push_back({22'h20, 22'h40, 22'h80});
    exp_q.push_back({22'h40, 22'h80, 22'h0});
    exp_q.push_back({22'h0,  22'h1,  22'h2});
    exp_q.push_back({22'h1,  22'h2,  22'h4});
    exp_q.push_back({22'h2,  22'h4,  22'h8});
    exp_q.push_back({22'h4,  22'h8,  22'h0});

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("rst_win_valid",  32'(wv4),   32'd0);
    chk("rst_win_row",    32'(wrow4), 32'd0);
    chk("rst_frame_done", 32'(fd4),   32'd0);
    chk("rst_top",        32'(top4),  32'd0);
    chk("rst_mid",        32'(mid4),  32'd0);
    chk("rst_bot",        32'(bot4),  32'd0);
    chk("rst_row_ready",  32'(rr4),   32'd1);

    // ---- table run ----
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].row, vecs[i].wr);
      @(negedge clk);
      chk($sformatf("v%0d_win_valid", i),  32'(wv4), 32'(vecs[i].wv));
      chk($sformatf("v%0d_row_ready", i),  32'(rr4), 32'(vecs[i].rr));
      chk($sformatf("v%0d_frame_done", i), 32'(fd4), 32'(vecs[i].fd));
      if (vecs[i].wv) begin
        chk($sformatf("v%0d_top", i),     32'(top4),  32'(vecs[i].top));
        chk($sformatf("v%0d_mid", i),     32'(mid4),  32'(vecs[i].mid));
        chk($sformatf("v%0d_bot", i),     32'(bot4),  32'(vecs[i].bot));
        chk($sformatf("v%0d_win_row", i), 32'(wrow4), 32'(vecs[i].wrow));
      end
`ifdef CONWAY_STALL_CNT_EN
      if (vecs[i].st_en)
        chk($sformatf("v%0d_stall_cnt", i), stall4, vecs[i].st);
`endif
    end
    drive(0, '0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    chk("mon_all_windows_seen", 32'(exp_q.size()), 32'd0);

    // ---- minimum frame (NUM_ROWS=2) ----
    do_reset();
    drive(1, 22'h3FFFFF, 1);
    @(negedge clk);
    chk("min_idle_ready", 32'(rr2), 32'd1);
    drive(1, 22'h155555, 1);
    @(negedge clk);
    chk("min_fill_wv", 32'(wv2), 32'd0);
    drive(0, '0, 1);
    @(negedge clk);
    chk("min_w0_valid", 32'(wv2),   32'd1);
    chk("min_w0_top",   32'(top2),  32'h0);
    chk("min_w0_mid",   32'(mid2),  32'h3FFFFF);
    chk("min_w0_bot",   32'(bot2),  32'h155555);
    chk("min_w0_row",   32'(wrow2), 32'd0);
    chk("min_w0_ready", 32'(rr2),   32'd0);
    drive(0, '0, 1);
    @(negedge clk);
    chk("min_w1_valid", 32'(wv2),   32'd1);
    chk("min_w1_top",   32'(top2),  32'h3FFFFF);
    chk("min_w1_mid",   32'(mid2),  32'h155555);
    chk("min_w1_bot",   32'(bot2),  32'h0);
    chk("min_w1_row",   32'(wrow2), 32'd1);
    chk("min_flush_ready", 32'(rr2), 32'd0);
    chk("min_w1_fd",    32'(fd2),   32'd0);
    drive(0, '0, 1);
    @(negedge clk);
    chk("min_done_valid", 32'(wv2), 32'd0);
    chk("min_done_pulse", 32'(fd2), 32'd1);

    // ---- reset mid-frame ----
    do_reset();
    drive(1, 22'hA, 1);
    drive(1, 22'hB, 1);
    drive(1, 22'hC, 1);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    row_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_win_valid", 32'(wv4),   32'd0);
    chk("mid_rst_win_row",   32'(wrow4), 32'd0);
    chk("mid_rst_row_ready", 32'(rr4),   32'd1);
    drive(1, 22'h100, 1);
    drive(1, 22'h200, 1);
    drive(0, '0, 0);
    @(negedge clk);
    chk("fresh_valid", 32'(wv4),   32'd1);
    chk("fresh_top",   32'(top4),  32'h0);
    chk("fresh_mid",   32'(mid4),  32'h100);
    chk("fresh_bot",   32'(bot4),  32'h200);
    chk("fresh_row",   32'(wrow4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
